bsg_nasti_write_arbiter: RTL and testbench
==========================================

BSG_NASTI_WRITE_ARBITER -- requirements
Module: bsg_nasti_write_arbiter

Interface
REQ-001 Parameter aw_width_p, default 64: AW payload width (bsg_nasti_a_pkt), opaque to the block.
REQ-002 Parameter w_width_p, default 137: W payload width (bsg_nasti_w_pkt); bit 0 is the last flag.
REQ-003 Parameter b_width_p, default 7: B payload width (bsg_nasti_b_pkt), opaque to the block.
REQ-004 Parameter order_els_p, default 4: depth of the outstanding-write order FIFO; power of two, at least 2.
REQ-005 Port clk_i  input  1: the single clock; all state changes on its rising edge.
REQ-006 Port reset_i  input  1: synchronous, active-high reset.
REQ-007 Port req_aw_valid_i  input  2; req_aw_data_i  input  2*aw_width_p; req_aw_ready_o  output  2: per-requester AW channel; requester n occupies slice n.
REQ-008 Port req_w_valid_i  input  2; req_w_data_i  input  2*w_width_p; req_w_ready_o  output  2: per-requester W channel.
REQ-009 Port req_b_valid_o  output  2; req_b_data_o  output  2*b_width_p; req_b_ready_i  input  2: per-requester B channel.
REQ-010 Port mem_aw_valid_o  output  1; mem_aw_data_o  output  aw_width_p; mem_aw_ready_i  input  1: shared downstream AW.
REQ-011 Port mem_w_valid_o  output  1; mem_w_data_o  output  w_width_p; mem_w_ready_i  input  1: shared downstream W.
REQ-012 Port mem_b_valid_i  input  1; mem_b_data_i  input  b_width_p; mem_b_ready_o  output  1: shared downstream B; downstream returns B in AW-acceptance order.

Function
REQ-013 FSM states: IDLE and BURST; the register owner_r (1 bit) holds the requester whose burst is active.
REQ-014 In IDLE with the order FIFO not full: winner = the valid requester selected by the round-robin pointer rr_r (priority to rr_r, then the other); mem_aw_valid_o = OR of req_aw_valid_i; mem_aw_data_o = winner's payload; only the winner's req_aw_ready_o = mem_aw_ready_i.
REQ-015 Outside IDLE, or with the order FIFO full: mem_aw_valid_o = 0 and all req_aw_ready_o = 0.
REQ-016 On an AW handshake: owner_r <= winner, push the winner onto the order FIFO, rr_r <= ~winner, and next state BURST.
REQ-017 In BURST: mem_w_valid_o/data = the owner's W; req_w_ready_o[owner_r] = mem_w_ready_i; the other requester's ready = 0; in IDLE all W ready = 0 and mem_w_valid_o = 0.
REQ-018 A W handshake with last = 1 in BURST returns the FSM to IDLE; the next AW grant is possible no earlier than the following cycle.
REQ-019 B routing: when the FIFO is non-empty with head h, req_b_valid_o[h] = mem_b_valid_i and mem_b_ready_o = req_b_ready_i[h]; req_b_data_o carries mem_b_data_i in both slices.
REQ-020 When the FIFO is empty: mem_b_ready_o = 0 and all req_b_valid_o = 0; a B handshake pops the head.
REQ-021 Push and pop in the same cycle are both honoured and the count is unchanged; push is never accepted when the FIFO is full, even with a concurrent pop.
REQ-022 FIFO pointers wrap modulo order_els_p; the count width is $clog2(order_els_p)+1.
REQ-023 Added latency is zero cycles on every channel (combinational forwarding); the only registers are the FSM state, owner_r, rr_r and the FIFO.

Reset
REQ-024 While reset_i = 1: state <= IDLE, owner_r <= 0, rr_r <= 0, FIFO emptied; all valid and ready outputs = 0 in that cycle.
REQ-025 A reset asserted mid-burst or with writes outstanding discards the in-flight state; no B is routed until a new AW is accepted.

Configuration
REQ-026 Macro BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN: when defined, requester 0 always wins in IDLE and rr_r is not implemented; when undefined, round-robin per REQ-014/REQ-016 applies.

Verification
REQ-027 Both AW valid from reset, all readys = 1, 2-beat bursts -> grant order 0,1,0,1; W beats never interleave; mem_aw_data_o matches the granted requester.
REQ-028 mem_b_ready withheld, 4 single-beat writes accepted -> 5th AW is not granted (mem_aw_valid_o = 0) until one B handshake occurs.
REQ-029 Requester 1 AW then requester 0 AW; downstream returns two B -> first B appears on req_b_valid_o[1], the second on [0].
REQ-030 reset_i pulsed for 1 cycle after the 2nd W beat of a 4-beat burst -> next cycle IDLE, FIFO empty, mem_b_ready_o = 0.
REQ-031 Macro defined, both requesters continuously valid -> requester 0 is granted on every AW.
REQ-032 Full FIFO with a B pop and a pending AW in the same cycle -> pop is taken, AW is not granted; AW is granted the next cycle.

Source files
------------

// File: rtl/bsg_nasti_write_arbiter.sv
// Two-requester NASTI write arbiter: AW arbitration, W burst locking, and B return routing via an order FIFO.
// Define BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN to make requester 0 always win instead of round-robin.
module bsg_nasti_write_arbiter #(
  parameter int aw_width_p  = 64,
  parameter int w_width_p   = 137,
  parameter int b_width_p   = 7,
  parameter int order_els_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [1:0]              req_aw_valid_i,
  input  logic [2*aw_width_p-1:0] req_aw_data_i,
  output logic [1:0]              req_aw_ready_o,

  input  logic [1:0]              req_w_valid_i,
  input  logic [2*w_width_p-1:0]  req_w_data_i,
  output logic [1:0]              req_w_ready_o,

  output logic [1:0]              req_b_valid_o,
  output logic [2*b_width_p-1:0]  req_b_data_o,
  input  logic [1:0]              req_b_ready_i,

  output logic                    mem_aw_valid_o,
  output logic [aw_width_p-1:0]   mem_aw_data_o,
  input  logic                    mem_aw_ready_i,

  output logic                    mem_w_valid_o,
  output logic [w_width_p-1:0]    mem_w_data_o,
  input  logic                    mem_w_ready_i,

  input  logic                    mem_b_valid_i,
  input  logic [b_width_p-1:0]    mem_b_data_i,
  output logic                    mem_b_ready_o
);

  localparam int ptr_w = $clog2(order_els_p);
  localparam int cnt_w = ptr_w + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e           state_r;
  logic             owner_r;
  logic [ptr_w-1:0] rd_ptr_r;
  logic [ptr_w-1:0] wr_ptr_r;
  logic [cnt_w-1:0] count_r;
  logic             order_mem [order_els_p];

  logic [aw_width_p-1:0] aw_data [2];
  logic [w_width_p-1:0]  w_data  [2];

  logic winner;
  logic fifo_full, fifo_empty, head;
  logic aw_en, w_en, b_en;
  logic aw_hs, w_last_hs, b_hs;

`ifdef BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN
  assign winner = ~req_aw_valid_i[0];
`else
  logic rr_r;
  // rr_r names the requester that gets first claim on the next grant
  assign winner = req_aw_valid_i[rr_r] ? rr_r : ~rr_r;
`endif

  assign fifo_full  = (count_r == cnt_w'(order_els_p));
  assign fifo_empty = (count_r == '0);
  assign head       = order_mem[rd_ptr_r];

  assign aw_en = ~reset_i & (state_r == IDLE) & ~fifo_full;
  assign w_en  = ~reset_i & (state_r == BURST);
  assign b_en  = ~reset_i & ~fifo_empty;

  assign mem_aw_valid_o = aw_en & (|req_aw_valid_i);
  assign mem_aw_data_o  = aw_data[winner];
  assign aw_hs          = mem_aw_valid_o & mem_aw_ready_i;

  assign mem_w_valid_o  = w_en & req_w_valid_i[owner_r];
  assign mem_w_data_o   = w_data[owner_r];
  assign w_last_hs      = mem_w_valid_o & mem_w_ready_i & mem_w_data_o[0];

  assign mem_b_ready_o  = b_en & req_b_ready_i[head];
  assign b_hs           = mem_b_valid_i & mem_b_ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign aw_data[gi] = req_aw_data_i[gi*aw_width_p +: aw_width_p];
      assign w_data[gi]  = req_w_data_i[gi*w_width_p +: w_width_p];
      assign req_aw_ready_o[gi] = aw_en & (winner == 1'(gi)) & mem_aw_ready_i;
      assign req_w_ready_o[gi]  = w_en & (owner_r == 1'(gi)) & mem_w_ready_i;
      assign req_b_valid_o[gi]  = b_en & (head == 1'(gi)) & mem_b_valid_i;
      assign req_b_data_o[gi*b_width_p +: b_width_p] = mem_b_data_i;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
`ifndef BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN
      rr_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (aw_hs) begin
            state_r <= BURST;
            owner_r <= winner;
          end
        end
        BURST: begin
          if (w_last_hs) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
`ifndef BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN
      if (aw_hs) rr_r <= ~winner;
`endif
      if (aw_hs) wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      if (b_hs)  rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      // push is already blocked when full, so simultaneous push/pop leaves count unchanged
      case ({aw_hs, b_hs})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) order_mem[wr_ptr_r] <= winner;
  end

endmodule

// File: tb/tb_bsg_nasti_write_arbiter.sv
// Randomized scoreboard bench for bsg_nasti_write_arbiter: a reference model of
// grants, W burst ordering and B return order checks the DUT every cycle.
module tb_bsg_nasti_write_arbiter;
  localparam int AW = 64;
  localparam int WW = 137;
  localparam int BW = 7;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i;
  logic [1:0]      req_aw_valid_i, req_aw_ready_o;
  logic [2*AW-1:0] req_aw_data_i;
  logic [1:0]      req_w_valid_i, req_w_ready_o;
  logic [2*WW-1:0] req_w_data_i;
  logic [1:0]      req_b_valid_o, req_b_ready_i;
  logic [2*BW-1:0] req_b_data_o;
  logic            mem_aw_valid_o, mem_aw_ready_i;
  logic [AW-1:0]   mem_aw_data_o;
  logic            mem_w_valid_o, mem_w_ready_i;
  logic [WW-1:0]   mem_w_data_o;
  logic            mem_b_valid_i, mem_b_ready_o;
  logic [BW-1:0]   mem_b_data_i;

  bsg_nasti_write_arbiter #(
    .aw_width_p(AW), .w_width_p(WW), .b_width_p(BW), .order_els_p(N)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_aw_valid_i(req_aw_valid_i), .req_aw_data_i(req_aw_data_i), .req_aw_ready_o(req_aw_ready_o),
    .req_w_valid_i(req_w_valid_i), .req_w_data_i(req_w_data_i), .req_w_ready_o(req_w_ready_o),
    .req_b_valid_o(req_b_valid_o), .req_b_data_o(req_b_data_o), .req_b_ready_i(req_b_ready_i),
    .mem_aw_valid_o(mem_aw_valid_o), .mem_aw_data_o(mem_aw_data_o), .mem_aw_ready_i(mem_aw_ready_i),
    .mem_w_valid_o(mem_w_valid_o), .mem_w_data_o(mem_w_data_o), .mem_w_ready_i(mem_w_ready_i),
    .mem_b_valid_i(mem_b_valid_i), .mem_b_data_i(mem_b_data_i), .mem_b_ready_o(mem_b_ready_o)
  );

  int errors = 0;
  int checks = 0;

  // stimulus knobs (percent probabilities)
  int p_aw, p_w, p_awr, p_wr, p_bv, p_br, p_rst_permil;
  int min_beats, max_beats;
  int phase = 0;

  // requester-side write descriptors, owned by the driver
  bit            has_wr   [2];
  bit            aw_done  [2];
  logic [AW-1:0] cur_aw   [2];
  logic [WW-1:0] wbeat    [2][8];
  int            nbeats   [2];
  int            bidx     [2];

  // handshakes observed by the monitor, consumed by the driver after the edge
  logic [1:0] aw_fire = '0;
  logic [1:0] w_fire  = '0;

  // reference model state, owned by the monitor
  bit            route_q [$];
  logic [WW-1:0] exp_w_q [$];
  bit            last_grant = 1'b1;
  bit            owner = 1'b0;
  int            grants [$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit pick(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  // Monitor / scoreboard: samples on the falling edge, between input updates and the active edge.
  always @(negedge clk) begin
    bit busy, full, has_head, head, exp_aw_v, win;
    if (reset_i) begin
      chk("reset_outputs", {req_aw_ready_o, req_w_ready_o, req_b_valid_o,
                            mem_aw_valid_o, mem_w_valid_o, mem_b_ready_o}, '0);
      route_q.delete();
      exp_w_q.delete();
      last_grant = 1'b1;
      aw_fire = '0;
      w_fire  = '0;
    end else begin
      busy     = exp_w_q.size() > 0;
      full     = route_q.size() >= N;
      has_head = route_q.size() > 0;
      head     = has_head ? route_q[0] : 1'b0;

      if (busy) begin
        chk("w_valid", mem_w_valid_o, req_w_valid_i[owner]);
        chk("w_ready", req_w_ready_o, mem_w_ready_i ? (2'b01 << owner) : 2'b00);
        if (mem_w_valid_o) chk("w_data", mem_w_data_o, exp_w_q[0]);
        if (mem_w_valid_o && mem_w_ready_i) void'(exp_w_q.pop_front());
      end else begin
        chk("w_idle", {mem_w_valid_o, req_w_ready_o}, '0);
      end

      if (has_head) begin
        chk("b_valid", req_b_valid_o, mem_b_valid_i ? (2'b01 << head) : 2'b00);
        chk("b_ready", mem_b_ready_o, req_b_ready_i[head]);
        if (mem_b_valid_i) chk("b_data", req_b_data_o, {2{mem_b_data_i}});
        if (mem_b_valid_i && req_b_ready_i[head]) begin
          $display("B   -> req%0d data=%0h", head, mem_b_data_i);
          void'(route_q.pop_front());
        end
      end else begin
        chk("b_empty", {req_b_valid_o, mem_b_ready_o}, '0);
      end

      exp_aw_v = !busy && !full && (|req_aw_valid_i);
      chk("aw_valid", mem_aw_valid_o, exp_aw_v);
      if (exp_aw_v) begin
`ifdef BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN
        win = req_aw_valid_i[0] ? 1'b0 : 1'b1;
`else
        // alternate when both ask; otherwise whoever asks wins
        win = (&req_aw_valid_i) ? ~last_grant : req_aw_valid_i[1];
`endif
        chk("aw_data", mem_aw_data_o, cur_aw[win]);
        chk("aw_ready", req_aw_ready_o, mem_aw_ready_i ? (2'b01 << win) : 2'b00);
        if (mem_aw_ready_i) begin
          $display("AW  grant req%0d beats=%0d addr=%0h", win, nbeats[win], cur_aw[win]);
          if (phase == 1) grants.push_back(req_aw_ready_o[1] ? 1 : 0);
          route_q.push_back(win);
          for (int k = 0; k < nbeats[win]; k++) exp_w_q.push_back(wbeat[win][k]);
          last_grant = win;
          owner = win;
        end
      end else begin
        chk("aw_ready_off", req_aw_ready_o, 2'b00);
      end

      aw_fire = req_aw_ready_o & req_aw_valid_i;
      w_fire  = req_w_ready_o & req_w_valid_i;
    end
  end

  task automatic new_write(input int n);
    logic [159:0] r;
    int nb;
    nb = $urandom_range(max_beats, min_beats);
    cur_aw[n] = {$urandom, $urandom};
    for (int k = 0; k < nb; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      wbeat[n][k] = r[WW-1:0];
      wbeat[n][k][0] = (k == nb - 1);
    end
    nbeats[n]  = nb;
    bidx[n]    = 0;
    aw_done[n] = 1'b0;
    has_wr[n]  = 1'b1;
  endtask

  task automatic run_cycles(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (reset_i) begin
        reset_i = 1'b0;
        for (int n = 0; n < 2; n++) has_wr[n] = 1'b0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (aw_fire[n]) aw_done[n] = 1'b1;
          if (w_fire[n])  bidx[n]++;
          if (has_wr[n] && aw_done[n] && bidx[n] >= nbeats[n]) has_wr[n] = 1'b0;
        end
        // inputs stay active during reset so output gating is exercised
        if ($urandom_range(999, 0) < p_rst_permil) reset_i = 1'b1;
      end
      for (int n = 0; n < 2; n++) begin
        if (!reset_i && !has_wr[n] && pick(p_aw)) new_write(n);
        req_aw_valid_i[n] = has_wr[n] && !aw_done[n];
        req_aw_data_i[n*AW +: AW] = cur_aw[n];
        req_w_valid_i[n] = has_wr[n] && (bidx[n] < nbeats[n]) && pick(p_w);
        req_w_data_i[n*WW +: WW] = (bidx[n] < nbeats[n]) ? wbeat[n][bidx[n]] : '0;
        req_b_ready_i[n] = pick(p_br);
      end
      mem_aw_ready_i = pick(p_awr);
      mem_w_ready_i  = pick(p_wr);
      mem_b_valid_i  = (route_q.size() > 0) && pick(p_bv);
      mem_b_data_i   = BW'($urandom);
    end
  endtask

  initial begin
    int exp_grants [4];
    reset_i = 1'b1;
    req_aw_valid_i = '0; req_aw_data_i = '0; req_w_valid_i = '0; req_w_data_i = '0;
    req_b_ready_i = '0; mem_aw_ready_i = 1'b0; mem_w_ready_i = 1'b0;
    mem_b_valid_i = 1'b0; mem_b_data_i = '0;
    for (int n = 0; n < 2; n++) begin
      has_wr[n] = 1'b0; aw_done[n] = 1'b0; nbeats[n] = 0; bidx[n] = 0; cur_aw[n] = '0;
    end
    repeat (3) @(posedge clk);

    // both requesters always valid, everything ready, 2-beat bursts
    phase = 1;
    p_aw = 100; p_w = 100; p_awr = 100; p_wr = 100; p_bv = 100; p_br = 100;
    p_rst_permil = 0; min_beats = 2; max_beats = 2;
    run_cycles(40);
`ifdef BSG_NASTI_WRITE_ARBITER_FIXED_PRIO_EN
    exp_grants = '{0, 0, 0, 0};
`else
    exp_grants = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++)
      chk("grant_order", (grants.size() > i) ? grants[i] : 9, exp_grants[i]);

    // B withheld: order FIFO fills with single-beat writes and blocks further AW
    phase = 2;
    p_aw = 80; p_w = 70; p_awr = 70; p_wr = 70; p_bv = 0; p_br = 80;
    min_beats = 1; max_beats = 1;
    run_cycles(150);
    @(negedge clk);
    chk("full_blocks_aw", mem_aw_valid_o, 1'b0);

    // B returns with contention: pops while full and pending AW
    p_bv = 30; p_awr = 90;
    run_cycles(300);

    // fully random traffic with occasional resets, longer bursts
    phase = 3;
    p_aw = 60; p_w = 60; p_awr = 60; p_wr = 60; p_bv = 50; p_br = 60;
    p_rst_permil = 5; min_beats = 1; max_beats = 4;
    run_cycles(2500);

    p_rst_permil = 0;
    run_cycles(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
